// File: rtl/quad_decoder.sv
// quad_decoder: quadrature A/B decoder producing registered increment/decrement/error pulses.
// Optional per-channel glitch filter is compiled in with `define QUAD_FILTER_EN.
module quad_decoder #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic quad_a,
    input  logic quad_b,
    output logic increment,
    output logic decrement,
    output logic error
);
    if (FILTER_LEN < 2 || FILTER_LEN > 16) begin : g_bad_len
        $error("quad_decoder: FILTER_LEN must be within 2..16");
    end

    logic [1:0] sync1_q, sync2_q;
    logic       vld1_q, vld2_q;
    logic [1:0] sample;
    logic       sample_vld;
    logic [1:0] prev_q;
    logic       primed_q;
    logic       inc_q, dec_q, err_q;
    logic       inc_d, dec_d, err_d;
    logic [1:0] pos_s, pos_p, step;
    logic       live;

    // Two-flop synchronizer per channel; the valid markers keep reset zeros from being taken as samples
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
            vld1_q  <= 1'b0;
            vld2_q  <= 1'b0;
        end else begin
            sync1_q <= {quad_a, quad_b};
            sync2_q <= sync1_q;
            vld1_q  <= 1'b1;
            vld2_q  <= vld1_q;
        end
    end

`ifdef QUAD_FILTER_EN
    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0] acc_d, acc_vld_d;

    for (genvar c = 0; c < 2; c++) begin : g_filt
        logic [CW-1:0] cnt_q, run;
        logic          samp_q, acc_q, acc_vld_q, hit;

        // Length of the current run of identical samples including this one, saturating at FILTER_LEN
        always_comb run = (sync2_q[c] == samp_q) ? ((cnt_q == CW'(FILTER_LEN)) ? cnt_q : cnt_q + 1'b1) : CW'(1);

        assign hit          = vld2_q && (run == CW'(FILTER_LEN));
        assign acc_d[c]     = hit ? sync2_q[c] : acc_q;
        assign acc_vld_d[c] = hit | acc_vld_q;

        // Run counter and accepted level; a broken run restarts the count at one
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q     <= '0;
                samp_q    <= 1'b0;
                acc_q     <= 1'b0;
                acc_vld_q <= 1'b0;
            end else if (vld2_q) begin
                cnt_q     <= run;
                samp_q    <= sync2_q[c];
                acc_q     <= acc_d[c];
                acc_vld_q <= acc_vld_d[c];
            end
        end
    end

    assign sample     = acc_d;
    assign sample_vld = &acc_vld_d;
`else
    assign sample     = sync2_q;
    assign sample_vld = vld2_q;
`endif

    // Gray position along the forward cycle 00->10->11->01, so a forward step is +1 mod 4
    assign pos_s = {sample[0], ^sample};
    assign pos_p = {prev_q[0], ^prev_q};
    assign step  = pos_s - pos_p;
    assign live  = sample_vld & primed_q & enable;

    // Classify the step between the previous and the newly accepted state
    always_comb begin
        inc_d = live && (step == 2'd1);
        dec_d = live && (step == 2'd3);
        err_d = live && (step == 2'd2);
    end

    // Prime on the first valid sample, then track every accepted sample regardless of enable
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q   <= 2'b00;
            primed_q <= 1'b0;
            inc_q    <= 1'b0;
            dec_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (sample_vld) begin
                prev_q   <= sample;
                primed_q <= 1'b1;
            end
            inc_q <= inc_d;
            dec_q <= dec_d;
            err_q <= err_d;
        end
    end

    assign increment = inc_q;
    assign decrement = dec_q;
    assign error     = err_q;
endmodule

// File: tb/tb_quad_decoder.sv
// tb_quad_decoder: table-driven, hand-sequenced and randomized checks of quad_decoder.
module tb_quad_decoder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic quad_a = 1'b0;
    logic quad_b = 1'b0;
    logic increment, decrement, error;

    int checks = 0;
    int errors = 0;

`ifdef QUAD_FILTER_EN
    localparam int LAT = 3 + 4 - 1;
`else
    localparam int LAT = 3;
`endif

    always #5 clk = ~clk;

    quad_decoder #(.FILTER_LEN(4)) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .quad_a(quad_a),
        .quad_b(quad_b),
        .increment(increment),
        .decrement(decrement),
        .error(error)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic [1:0] ab;
        int         hold;
        int         inc;
        int         dec;
        int         err;
    } step_t;

    step_t tbl[$];

    function automatic step_t mk(logic r, logic e, logic [1:0] ab, int h, int i, int d, int x);
        step_t s;
        s.rst = r; s.en = e; s.ab = ab; s.hold = h; s.inc = i; s.dec = d; s.err = x;
        return s;
    endfunction

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(logic r, logic e, logic [1:0] ab);
        reset  = r;
        enable = e;
        {quad_a, quad_b} = ab;
    endtask

    task automatic run(int n, output int ni, output int nd, output int ne);
        ni = 0; nd = 0; ne = 0;
        repeat (n) begin
            @(posedge clk); #1;
            ni += int'(increment);
            nd += int'(decrement);
            ne += int'(error);
        end
    endtask

    int pos_of[4] = '{0, 3, 1, 2};
    int ab_of[4]  = '{0, 2, 3, 1};

    initial begin
        int ni, nd, ne;
        logic [1:0] cur;
        logic [1:0] xh[400];
        logic       eh[400];

        tbl.push_back(mk(1'b1, 1'b0, 2'b00, 4, 0, 0, 0));
        tbl.push_back(mk(1'b0, 1'b1, 2'b00, 8, 0, 0, 0));
        tbl.push_back(mk(1'b0, 1'b1, 2'b10, 8, 1, 0, 0));
        tbl.push_back(mk(1'b0, 1'b1, 2'b11, 8, 1, 0, 0));
        tbl.push_back(mk(1'b0, 1'b1, 2'b01, 8, 1, 0, 0));
        tbl.push_back(mk(1'b0, 1'b1, 2'b00, 8, 1, 0, 0));
        tbl.push_back(mk(1'b0, 1'b1, 2'b01, 8, 0, 1, 0));
        tbl.push_back(mk(1'b0, 1'b1, 2'b11, 8, 0, 1, 0));
        tbl.push_back(mk(1'b0, 1'b1, 2'b10, 8, 0, 1, 0));
        tbl.push_back(mk(1'b0, 1'b1, 2'b00, 8, 0, 1, 0));
        tbl.push_back(mk(1'b0, 1'b1, 2'b11, 8, 0, 0, 1));
        tbl.push_back(mk(1'b0, 1'b1, 2'b01, 8, 1, 0, 0));
        tbl.push_back(mk(1'b0, 1'b1, 2'b00, 8, 1, 0, 0));
        tbl.push_back(mk(1'b1, 1'b1, 2'b11, 4, 0, 0, 0));
        tbl.push_back(mk(1'b0, 1'b1, 2'b11, 8, 0, 0, 0));
        tbl.push_back(mk(1'b0, 1'b0, 2'b01, 8, 0, 0, 0));
        tbl.push_back(mk(1'b0, 1'b0, 2'b00, 8, 0, 0, 0));
        tbl.push_back(mk(1'b0, 1'b1, 2'b00, 8, 0, 0, 0));
        tbl.push_back(mk(1'b0, 1'b1, 2'b10, 8, 1, 0, 0));

        drive(1'b1, 1'b0, 2'b00);
        @(posedge clk); #1;
        chk("reset outputs", int'({increment, decrement, error}), 0);

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].en, tbl[i].ab);
            run(tbl[i].hold, ni, nd, ne);
            chk($sformatf("row%0d inc", i), ni, tbl[i].inc);
            chk($sformatf("row%0d dec", i), nd, tbl[i].dec);
            chk($sformatf("row%0d err", i), ne, tbl[i].err);
        end

        // latency of a single forward step 10->11
        drive(1'b0, 1'b1, 2'b11);
        for (int j = 1; j <= LAT + 1; j++) begin
            @(posedge clk); #1;
            chk($sformatf("latency edge%0d inc", j), int'(increment), int'(j == LAT));
        end
        run(4, ni, nd, ne);

        // reset one cycle after an input change discards the pending pulse
        drive(1'b0, 1'b1, 2'b01);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("after mid-step reset", int'({increment, decrement, error}), 0);
        reset = 1'b0;
        run(8, ni, nd, ne);
        chk("post reset pulses", ni + nd + ne, 0);
        drive(1'b0, 1'b1, 2'b00);
        run(8, ni, nd, ne);
        chk("post reset step inc", ni, 1);
        chk("post reset step dec", nd + ne, 0);

`ifdef QUAD_FILTER_EN
        // a 2-cycle glitch on A is rejected, a long level is accepted after LAT edges
        drive(1'b0, 1'b1, 2'b10);
        run(2, ni, nd, ne);
        drive(1'b0, 1'b1, 2'b00);
        run(8, ni, nd, ne);
        chk("glitch pulses", ni + nd + ne, 0);
        drive(1'b0, 1'b1, 2'b10);
        for (int j = 1; j <= 7; j++) begin
            @(posedge clk); #1;
            chk($sformatf("filter latency edge%0d inc", j), int'(increment), int'(j == 6));
        end
        run(3, ni, nd, ne);
        chk("filter tail pulses", ni + nd + ne, 0);
`else
        // random walk against a position-arithmetic model
        cur = {quad_a, quad_b};
        for (int i = 0; i < 400; i++) begin
            if (i < 3) begin
                xh[i] = cur;
                eh[i] = 1'b1;
            end else begin
                int r, dlt;
                r = int'($urandom_range(0, 9));
                dlt = (r < 4) ? 1 : (r < 7) ? 3 : (r == 7) ? 2 : 0;
                cur = 2'(ab_of[(pos_of[cur] + dlt) % 4]);
                xh[i] = cur;
                eh[i] = ($urandom_range(0, 3) != 0);
            end
            drive(1'b0, eh[i], xh[i]);
            @(posedge clk); #1;
            if (i >= 3) begin
                int d, exp;
                d = (pos_of[xh[i - 2]] - pos_of[xh[i - 3]] + 4) % 4;
                exp = eh[i] ? ((d == 1) ? 4 : (d == 3) ? 2 : (d == 2) ? 1 : 0) : 0;
                chk($sformatf("rand cyc%0d {inc,dec,err}", i), int'({increment, decrement, error}), exp);
            end
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
